// File: rtl/ru_pkg.sv
// Shared definitions for the remote-update sequencer: parameter codes,
// reason bit positions, data widths and the FSM/access-phase encodings.
package ru_pkg;

  localparam int RU_DATA_W   = 22;
  localparam int RU_DOUT_W   = 24;
  localparam int RU_REASON_W = 5;

  localparam logic [2:0] RU_P_CDONE  = 3'b001;
  localparam logic [2:0] RU_P_WD_VAL = 3'b010;
  localparam logic [2:0] RU_P_WD_EN  = 3'b011;
  localparam logic [2:0] RU_P_BOOT   = 3'b100;
  localparam logic [2:0] RU_P_OSC    = 3'b110;
  localparam logic [2:0] RU_P_REASON = 3'b111;

  localparam int RU_R_CRC = 3;
  localparam int RU_R_WD  = 1;

  typedef enum logic [3:0] {
    ST_RU_RST,
    ST_INIT,
    ST_WR_CDONE,
    ST_WR_OSC,
    ST_WAIT_ADDR,
    ST_WR_ADDR,
    ST_WR_WD_VAL,
    ST_WR_WD_EN,
    ST_RD_REASON,
    ST_CHECK,
    ST_ARMED,
    ST_HOLD,
    ST_DONE
  } ru_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_GUARD,
    PH_POLL,
    PH_ACK
  } ru_phase_e;

endpackage

// File: rtl/ru_param_access.sv
// One parameter read/write on the Remote Update megafunction:
// setup -> one-cycle strobe -> guard (busy ignored) -> poll busy low -> ack.
module ru_param_access
  import ru_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rd,
  input  logic [2:0]           param,
  input  logic [RU_DATA_W-1:0] wdata,
  output logic                 ack,
  output logic [RU_DOUT_W-1:0] rdata,
  input  logic                 ru_busy,
  input  logic [RU_DOUT_W-1:0] ru_data_out,
  output logic                 ru_write_param,
  output logic                 ru_read_param,
  output logic [2:0]           ru_param,
  output logic [RU_DATA_W-1:0] ru_data_in
);

  ru_phase_e            phase_q, phase_d;
  logic                 rd_q, rd_d;
  logic [2:0]           param_q, param_d;
  logic [RU_DATA_W-1:0] wdata_q, wdata_d;
  logic [RU_DOUT_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      rd_q    <= 1'b0;
      param_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      rd_q    <= rd_d;
      param_q <= param_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/data are only reloaded on start, so they stay put through the poll.
  always_comb begin
    phase_d = phase_q;
    rd_d    = rd_q;
    param_d = param_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (phase_q)
      PH_IDLE: begin
        if (start) begin
          rd_d    = rd;
          param_d = param;
          wdata_d = rd ? '0 : wdata;
          phase_d = PH_SETUP;
        end
      end
      PH_SETUP:  phase_d = PH_STROBE;
      PH_STROBE: phase_d = PH_GUARD;
      PH_GUARD:  phase_d = PH_POLL;
      PH_POLL: begin
        if (!ru_busy) begin
          rdata_d = ru_data_out;
          phase_d = PH_ACK;
        end
      end
      PH_ACK:    phase_d = PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase
  end

  assign ack            = (phase_q == PH_ACK);
  assign rdata          = rdata_q;
  assign ru_write_param = (phase_q == PH_STROBE) && !rd_q;
  assign ru_read_param  = (phase_q == PH_STROBE) && rd_q;
  assign ru_param       = param_q;
  assign ru_data_in     = wdata_q;

endmodule

// File: rtl/remote_update_seq.sv
// Boot-time remote-update sequencer: programs CONF_DONE, oscillator, boot
// address and watchdog, reads the reconfig reason, then reconfigures on command.
// RU_WATCHDOG_EN enables the watchdog; otherwise the timeout write is skipped
// and the watchdog is written disabled.
module remote_update_seq
  import ru_pkg::*;
#(
  parameter int         ADDR_W      = 24,
  parameter int         N_IMAGES    = 2,
  parameter int         HOLD_CYCLES = 4,
  parameter logic [11:0] WD_TIMEOUT = 12'hFFF,
  localparam int        SEL_W       = (N_IMAGES > 1) ? $clog2(N_IMAGES) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IMAGES*ADDR_W-1:0] boot_addr,
  input  logic [SEL_W-1:0]         image_sel,
  input  logic                     addr_ready,
  input  logic                     control,
  output logic                     crc_error,
  output logic                     wd_error,
  output logic [4:0]               reason,
  output logic [SEL_W-1:0]         sel_latched,
  output logic                     done,
  output logic                     ru_reset,
  output logic                     ru_write_param,
  output logic                     ru_read_param,
  output logic [2:0]               ru_param,
  output logic [21:0]              ru_data_in,
  output logic [1:0]               ru_read_source,
  output logic                     ru_reconfig,
  input  logic                     ru_busy,
  input  logic [23:0]              ru_data_out
);

  localparam int N_SLOTS = 1 << SEL_W;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef RU_WATCHDOG_EN
  localparam logic [RU_DATA_W-1:0] WD_EN_DATA = RU_DATA_W'(1);
`else
  localparam logic [RU_DATA_W-1:0] WD_EN_DATA = '0;
`endif

  ru_state_e               state_q, state_d;
  logic                    issued_q, issued_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [RU_REASON_W-1:0]  reason_q, reason_d;
  logic                    crc_q, crc_d;
  logic                    wd_q, wd_d;

  logic                    acc_start;
  logic                    acc_rd;
  logic [2:0]              acc_param;
  logic [RU_DATA_W-1:0]    acc_wdata;
  logic                    acc_ack;
  logic [RU_DOUT_W-1:0]    acc_rdata;
  logic                    is_access;
  logic                    rdata_unused;

  // Image table padded to a power of two so any image_sel value indexes safely.
  logic [ADDR_W-1:0] img_addr [N_SLOTS];
  logic [SEL_W-1:0]  sel_eff;

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_img
    if (gi < N_IMAGES) begin : g_real
      assign img_addr[gi] = boot_addr[gi*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign img_addr[gi] = '0;
    end
  end

  assign sel_eff      = (int'(image_sel) < N_IMAGES) ? image_sel : '0;
  assign rdata_unused = ^acc_rdata[RU_DOUT_W-1:RU_REASON_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RU_RST;
      issued_q   <= 1'b0;
      hold_cnt_q <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      reason_q   <= '0;
      crc_q      <= 1'b0;
      wd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      reason_q   <= reason_d;
      crc_q      <= crc_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    reason_d   = reason_q;
    crc_d      = crc_q;
    wd_d       = wd_q;
    is_access  = 1'b0;
    acc_rd     = 1'b0;
    acc_param  = RU_P_CDONE;
    acc_wdata  = '0;

    case (state_q)
      ST_RU_RST: begin
        if (!ru_busy) state_d = ST_INIT;
      end
      ST_INIT: begin
        crc_d    = 1'b0;
        wd_d     = 1'b0;
        reason_d = '0;
        state_d  = ST_WR_CDONE;
      end
      ST_WR_CDONE: begin
        is_access = 1'b1;
        acc_param = RU_P_CDONE;
        acc_wdata = RU_DATA_W'(1);
        if (acc_ack) state_d = ST_WR_OSC;
      end
      ST_WR_OSC: begin
        is_access = 1'b1;
        acc_param = RU_P_OSC;
        acc_wdata = RU_DATA_W'(1);
        if (acc_ack) state_d = ST_WAIT_ADDR;
      end
      ST_WAIT_ADDR: begin
        if (addr_ready) begin
          sel_d   = sel_eff;
          addr_d  = img_addr[sel_eff];
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        is_access = 1'b1;
        acc_param = RU_P_BOOT;
        acc_wdata = RU_DATA_W'(addr_q >> 2);
        if (acc_ack) begin
`ifdef RU_WATCHDOG_EN
          state_d = ST_WR_WD_VAL;
`else
          state_d = ST_WR_WD_EN;
`endif
        end
      end
`ifdef RU_WATCHDOG_EN
      ST_WR_WD_VAL: begin
        is_access = 1'b1;
        acc_param = RU_P_WD_VAL;
        acc_wdata = RU_DATA_W'(WD_TIMEOUT);
        if (acc_ack) state_d = ST_WR_WD_EN;
      end
`endif
      ST_WR_WD_EN: begin
        is_access = 1'b1;
        acc_param = RU_P_WD_EN;
        acc_wdata = WD_EN_DATA;
        if (acc_ack) state_d = ST_RD_REASON;
      end
      ST_RD_REASON: begin
        is_access = 1'b1;
        acc_rd    = 1'b1;
        acc_param = RU_P_REASON;
        if (acc_ack) begin
          reason_d = acc_rdata[RU_REASON_W-1:0];
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reason_q[RU_R_CRC]) begin
          crc_d   = 1'b1;
          state_d = ST_DONE;
        end else if (reason_q[RU_R_WD]) begin
          wd_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        hold_cnt_d = '0;
        if (!control) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_DONE;
        else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RU_RST;
    endcase

    // Exactly one start per access state; the flag drops with the ack.
    if (acc_start) issued_d = 1'b1;
    else if (acc_ack) issued_d = 1'b0;
  end

  assign acc_start = is_access && !issued_q;

  ru_param_access u_access (
    .clock          (clock),
    .reset          (reset),
    .start          (acc_start),
    .rd             (acc_rd),
    .param          (acc_param),
    .wdata          (acc_wdata),
    .ack            (acc_ack),
    .rdata          (acc_rdata),
    .ru_busy        (ru_busy),
    .ru_data_out    (ru_data_out),
    .ru_write_param (ru_write_param),
    .ru_read_param  (ru_read_param),
    .ru_param       (ru_param),
    .ru_data_in     (ru_data_in)
  );

  assign ru_reset       = (state_q == ST_RU_RST);
  assign ru_reconfig    = (state_q == ST_HOLD);
  assign done           = (state_q == ST_DONE);
  assign ru_read_source = 2'b00;
  assign crc_error      = crc_q;
  assign wd_error       = wd_q;
  assign reason         = reason_q;
  assign sel_latched    = sel_q;

endmodule

// File: tb/tb_remote_update_seq.sv
// Directed bench for remote_update_seq: megafunction busy model plus access
// logger, and one task per scenario with hand-computed expectations.
module tb_remote_update_seq;

  localparam int N_IMG = 3;
`ifdef RU_WATCHDOG_EN
  localparam int N_ACC = 6;
`else
  localparam int N_ACC = 5;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [3*24-1:0]   boot_addr = {24'h0C0000, 24'h100000, 24'h0A0000};
  logic [1:0]        image_sel = 2'd1;
  logic              addr_ready = 1'b0;
  logic              control = 1'b1;
  logic              crc_error, wd_error, done;
  logic [4:0]        reason;
  logic [1:0]        sel_latched;
  logic              ru_reset, ru_write_param, ru_read_param, ru_reconfig;
  logic [2:0]        ru_param;
  logic [21:0]       ru_data_in;
  logic [1:0]        ru_read_source;
  logic              ru_busy = 1'b0;
  logic [4:0]        reason_drv = 5'd0;
  logic [23:0]       ru_data_out;

  assign ru_data_out = {19'h2A5A5, reason_drv};

  always #5 clock = ~clock;

  remote_update_seq #(
    .ADDR_W(24), .N_IMAGES(N_IMG), .HOLD_CYCLES(4), .WD_TIMEOUT(12'hFFF)
  ) dut (
    .clock(clock), .reset(reset), .boot_addr(boot_addr), .image_sel(image_sel),
    .addr_ready(addr_ready), .control(control), .crc_error(crc_error),
    .wd_error(wd_error), .reason(reason), .sel_latched(sel_latched), .done(done),
    .ru_reset(ru_reset), .ru_write_param(ru_write_param), .ru_read_param(ru_read_param),
    .ru_param(ru_param), .ru_data_in(ru_data_in), .ru_read_source(ru_read_source),
    .ru_reconfig(ru_reconfig), .ru_busy(ru_busy), .ru_data_out(ru_data_out)
  );

  int tests = 0;
  int fails = 0;

  logic [2:0]  log_param [$];
  logic [21:0] log_data  [$];
  bit          log_rd    [$];
  logic [2:0]  exp_param [N_ACC];
  logic [21:0] exp_data  [N_ACC];
  bit          exp_rd    [N_ACC];

  int          busy_cnt = 0;
  bit          prev_strobe = 0;
  bit          strobe_now;
  bit          reconfig_seen = 0;
  logic [2:0]  held_param;
  logic [21:0] held_data;

  // Busy model: high for three cycles after each strobe; logs every access.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      strobe_now = ru_write_param | ru_read_param;
      if (strobe_now) begin
        tests++;
        if (prev_strobe) begin
          fails++;
          $display("FAIL strobe_width: strobe high in consecutive cycles, param %03b", ru_param);
        end
        log_param.push_back(ru_param);
        log_data.push_back(ru_data_in);
        log_rd.push_back(ru_read_param);
        held_param = ru_param;
        held_data  = ru_data_in;
        busy_cnt   = 3;
      end else if (busy_cnt > 0) begin
        tests++;
        if (ru_param !== held_param || ru_data_in !== held_data) begin
          fails++;
          $display("FAIL param_stable: got %03b/%06h required %03b/%06h",
                   ru_param, ru_data_in, held_param, held_data);
        end
        busy_cnt--;
      end
      prev_strobe = strobe_now;
      ru_busy = (busy_cnt > 0);
      if (ru_reconfig) reconfig_seen = 1;
    end else begin
      busy_cnt    = 0;
      prev_strobe = 0;
      ru_busy     = 1'b0;
    end
  end

  task automatic clear_log();
    log_param.delete();
    log_data.delete();
    log_rd.delete();
    reconfig_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    clear_log();
    reset = 1'b1;
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #1;
      if (log_param.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #1;
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic build_expected();
    exp_param[0] = 3'b001; exp_data[0] = 22'd1; exp_rd[0] = 0;
    exp_param[1] = 3'b110; exp_data[1] = 22'd1; exp_rd[1] = 0;
    exp_param[2] = 3'b100; exp_data[2] = 22'h040000; exp_rd[2] = 0;
`ifdef RU_WATCHDOG_EN
    exp_param[3] = 3'b010; exp_data[3] = 22'h000FFF; exp_rd[3] = 0;
    exp_param[4] = 3'b011; exp_data[4] = 22'd1; exp_rd[4] = 0;
    exp_param[5] = 3'b111; exp_data[5] = 22'd0; exp_rd[5] = 1;
`else
    exp_param[3] = 3'b011; exp_data[3] = 22'd0; exp_rd[3] = 0;
    exp_param[4] = 3'b111; exp_data[4] = 22'd0; exp_rd[4] = 1;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests++;
    if (ru_reset !== 1'b1) begin
      fails++; $display("FAIL reset_ru_reset: got %b required 1", ru_reset);
    end
    tests++;
    if ({ru_write_param, ru_read_param, ru_reconfig, done, crc_error, wd_error} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %06b required 000000",
               {ru_write_param, ru_read_param, ru_reconfig, done, crc_error, wd_error});
    end
    tests++;
    if ({ru_param, ru_data_in, ru_read_source, reason, sel_latched} !== 34'b0) begin
      fails++;
      $display("FAIL reset_values: got %09h required 0",
               {ru_param, ru_data_in, ru_read_source, reason, sel_latched});
    end
  endtask

  task automatic test_boot();
    bit ok;
    int cnt, first_idx, done_idx;
    reason_drv = 5'b00000; control = 1'b1; addr_ready = 1'b0; image_sel = 2'd1;
    do_reset();
    wait_log(2, ok);
    // Early control glitch must be ignored.
    control = 1'b0; @(negedge clock); control = 1'b1;
    repeat (30) @(negedge clock);
    #1;
    tests++;
    if (!ok || log_param.size() != 2) begin
      fails++; $display("FAIL wait_addr_park: got %0d accesses required 2", log_param.size());
    end
    addr_ready = 1'b1;
    wait_log(N_ACC, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL boot_timeout: got %0d accesses required %0d", log_param.size(), N_ACC);
    end
    for (int i = 0; i < N_ACC && i < log_param.size(); i++) begin
      tests++;
      if (log_param[i] !== exp_param[i] || log_rd[i] !== exp_rd[i] ||
          (!exp_rd[i] && log_data[i] !== exp_data[i])) begin
        fails++;
        $display("FAIL boot_seq[%0d]: got %03b/%0b/%06h required %03b/%0b/%06h", i,
                 log_param[i], log_rd[i], log_data[i], exp_param[i], exp_rd[i], exp_data[i]);
      end
    end
    tests++;
    if (sel_latched !== 2'd1) begin
      fails++; $display("FAIL boot_sel: got %0d required 1", sel_latched);
    end
    repeat (50) @(negedge clock);
    tests++;
    if (reconfig_seen || done !== 1'b0 || crc_error !== 1'b0 || wd_error !== 1'b0 || reason !== 5'd0) begin
      fails++;
      $display("FAIL armed_idle: got reconf %0b done %b crc %b wd %b reason %05b required 0",
               reconfig_seen, done, crc_error, wd_error, reason);
    end
    control = 1'b0;
    cnt = 0; first_idx = -1; done_idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ru_reconfig === 1'b1) begin
        cnt++;
        if (first_idx < 0) first_idx = i;
      end
      if (done === 1'b1 && done_idx < 0) done_idx = i;
    end
    control = 1'b1;
    tests++;
    if (cnt != 4 || first_idx != 0) begin
      fails++; $display("FAIL hold_len: got %0d cycles from %0d required 4 from 0", cnt, first_idx);
    end
    tests++;
    if (done_idx != 4 || done !== 1'b1) begin
      fails++; $display("FAIL done_rise: got index %0d required 4", done_idx);
    end
  endtask

  task automatic test_error_paths();
    bit ok;
    logic [4:0] vec_reason [3] = '{5'b01000, 5'b00010, 5'b01010};
    logic [1:0] vec_flags  [3] = '{2'b10, 2'b01, 2'b10};
    for (int t = 0; t < 3; t++) begin
      reason_drv = vec_reason[t]; control = 1'b0; addr_ready = 1'b1; image_sel = 2'd0;
      do_reset();
      wait_done(ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL err_done[%0d]: done never rose", t);
      end
      tests++;
      if ({crc_error, wd_error} !== vec_flags[t] || reason !== vec_reason[t]) begin
        fails++;
        $display("FAIL err_flags[%0d]: got crc/wd %b%b reason %05b required %02b reason %05b",
                 t, crc_error, wd_error, reason, vec_flags[t], vec_reason[t]);
      end
      repeat (10) @(negedge clock);
      tests++;
      if (reconfig_seen || done !== 1'b1) begin
        fails++; $display("FAIL err_noreconf[%0d]: got reconf %0b done %b required 0/1", t, reconfig_seen, done);
      end
    end
    control = 1'b1;
  endtask

  task automatic test_image_select();
    bit ok;
    logic [1:0]  vec_sel  [3] = '{2'd3, 2'd2, 2'd0};
    logic [1:0]  vec_lat  [3] = '{2'd0, 2'd2, 2'd0};
    logic [21:0] vec_data [3] = '{22'h028000, 22'h030000, 22'h028000};
    for (int t = 0; t < 3; t++) begin
      reason_drv = 5'd0; control = 1'b1; addr_ready = 1'b1; image_sel = vec_sel[t];
      do_reset();
      wait_log(3, ok);
      tests++;
      if (!ok || log_param[2] !== 3'b100 || log_data[2] !== vec_data[t]) begin
        fails++;
        $display("FAIL img_addr[%0d]: got %06h required %06h", t,
                 (log_data.size() > 2) ? log_data[2] : 22'h0, vec_data[t]);
      end
      tests++;
      if (sel_latched !== vec_lat[t]) begin
        fails++; $display("FAIL img_sel[%0d]: got %0d required %0d", t, sel_latched, vec_lat[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    reason_drv = 5'd0; control = 1'b1; addr_ready = 1'b1; image_sel = 2'd1;
    do_reset();
    wait_log(3, ok);
    // Strobe for param 100 was logged; two more negedges lands in the poll phase.
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (!ok || ru_reset !== 1'b1 || ru_param !== 3'b000 || ru_data_in !== 22'd0) begin
      fails++;
      $display("FAIL midrst_drive: got rst %b param %03b data %06h required 1/000/000000",
               ru_reset, ru_param, ru_data_in);
    end
    tests++;
    if ({ru_write_param, ru_read_param, ru_reconfig, done, sel_latched} !== 6'b0) begin
      fails++;
      $display("FAIL midrst_flags: got %06b required 000000",
               {ru_write_param, ru_read_param, ru_reconfig, done, sel_latched});
    end
    repeat (2) @(negedge clock);
    clear_log();
    reset = 1'b1;
    wait_log(N_ACC, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL midrst_replay: got %0d accesses required %0d", log_param.size(), N_ACC);
    end
    for (int i = 0; i < N_ACC && i < log_param.size(); i++) begin
      tests++;
      if (log_param[i] !== exp_param[i] || (!exp_rd[i] && log_data[i] !== exp_data[i])) begin
        fails++;
        $display("FAIL midrst_seq[%0d]: got %03b/%06h required %03b/%06h", i,
                 log_param[i], log_data[i], exp_param[i], exp_data[i]);
      end
    end
    repeat (10) @(negedge clock);
    control = 1'b0;
    wait_done(ok);
    control = 1'b1;
    tests++;
    if (!ok || !reconfig_seen) begin
      fails++; $display("FAIL midrst_done: got done %b reconf %0b required 1/1", done, reconfig_seen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    build_expected();
    test_reset();
    test_boot();
    test_error_paths();
    test_image_select();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
